// File: rtl/mm_wb_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mm_wb_buffer : de-skews diagonal MXU result bytes into row entries and      |
// |                writes completed rows, in order, to the scratch RAM.         |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mm_wb_buffer #(
   parameter int LANES = 16,
   parameter int DW    = 8,
   parameter int AW    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      lsu_mm_wb_ctrl_vld,
   input  logic [$clog2(LANES)-1:0]  lsu_mm_wb_ctrl_row_len,
   input  logic [$clog2(LANES)-1:0]  lsu_mm_wb_ctrl_col_len,
   input  logic [AW+$clog2(LANES)-1:0] lsu_mm_wb_ctrl_start_addr,
   output logic                      lsu_mm_wb_busy,
   output logic                      lsu_mm_wb_done,
   input  logic [LANES-1:0]          mxu_mm_wb_vld,
   input  logic [LANES*DW-1:0]       mxu_mm_wb_data,
   output logic                      lsu_mm_wb_ram_wr_vld,
   input  logic                      lsu_mm_wb_ram_wr_rdy,
   output logic [AW-1:0]             lsu_mm_wb_ram_wr_addr,
   output logic [LANES*DW-1:0]       lsu_mm_wb_ram_wr_data,
   output logic [LANES-1:0]          lsu_mm_wb_ram_wr_mask
);

   localparam int LW = $clog2(LANES);
   localparam int RW = LANES * DW;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [LW-1:0]   r_row_len;
   logic [LW-1:0]   r_col_len;
   logic [AW-1:0]   r_base;
   logic [LW:0]     r_lane_row [LANES];
   logic [LANES-1:0] r_row_done;
   logic [LW:0]     r_wr_ptr;
   logic [RW-1:0]   r_entry [LANES];

   logic            r_busy;
   logic            r_done;
   logic            r_wr_vld;
   logic [AW-1:0]   r_wr_addr;
   logic [RW-1:0]   r_wr_data;
   logic [LANES-1:0] r_wr_mask;

   logic            w_accept;
   logic            w_issue;
   logic [LW:0]     w_wr_ptr_nxt;
   logic [LANES-1:0] w_cap;
   logic [LANES-1:0] w_done_set;
   logic [LANES-1:0] w_row_done_nxt;
   logic [LANES-1:0] w_mask;
   logic [RW-1:0]   w_wr_data;

   always_comb begin
      w_accept     = r_wr_vld & lsu_mm_wb_ram_wr_rdy;
      w_wr_ptr_nxt = r_wr_ptr + {{LW{1'b0}}, w_accept};
      w_cap        = '0;
      w_done_set   = '0;
      w_mask       = '0;
      w_wr_data    = '0;
      for (int j = 0; j < LANES; j++) begin
         w_mask[j] = (LW'(j) <= r_col_len);
         w_cap[j]  = (r_state == S_COLLECT) && mxu_mm_wb_vld[j] &&
                     (LW'(j) <= r_col_len) && (r_lane_row[j] <= {1'b0, r_row_len});
      end
      // A capture on the last active lane closes the row it lands in.
      if (w_cap[r_col_len])
         w_done_set[r_lane_row[r_col_len][LW-1:0]] = 1'b1;
      w_row_done_nxt = r_row_done | w_done_set;
      w_issue = (w_wr_ptr_nxt <= {1'b0, r_row_len}) && w_row_done_nxt[w_wr_ptr_nxt[LW-1:0]];
      // Bytes landing this edge in the row about to be presented bypass the entry.
      for (int j = 0; j < LANES; j++) begin
         if (w_cap[j] && (r_lane_row[j][LW-1:0] == w_wr_ptr_nxt[LW-1:0]))
            w_wr_data[j*DW +: DW] = mxu_mm_wb_data[j*DW +: DW];
         else
            w_wr_data[j*DW +: DW] = r_entry[w_wr_ptr_nxt[LW-1:0]][j*DW +: DW];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (lsu_mm_wb_ctrl_vld) w_state_nxt = S_COLLECT;
         S_COLLECT: if (w_row_done_nxt[r_row_len]) w_state_nxt = S_DRAIN;
         S_DRAIN:   if (w_accept && (r_wr_ptr == {1'b0, r_row_len})) w_state_nxt = S_DONE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_row_len  <= '0;
         r_col_len  <= '0;
         r_base     <= '0;
         r_row_done <= '0;
         r_wr_ptr   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wr_vld   <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_mask  <= '0;
         for (int j = 0; j < LANES; j++) r_lane_row[j] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= (w_state_nxt == S_DONE);
         case (r_state)
            S_IDLE: begin
               r_wr_vld <= 1'b0;
               if (lsu_mm_wb_ctrl_vld) begin
                  r_row_len  <= lsu_mm_wb_ctrl_row_len;
                  r_col_len  <= lsu_mm_wb_ctrl_col_len;
                  r_base     <= lsu_mm_wb_ctrl_start_addr[AW+LW-1:LW];
                  r_row_done <= '0;
                  r_wr_ptr   <= '0;
                  for (int j = 0; j < LANES; j++) r_lane_row[j] <= '0;
               end
            end
            S_COLLECT, S_DRAIN: begin
               for (int j = 0; j < LANES; j++)
                  if (w_cap[j]) r_lane_row[j] <= r_lane_row[j] + (LW+1)'(1);
               r_row_done <= w_row_done_nxt;
               r_wr_ptr   <= w_wr_ptr_nxt;
               // A presented write holds until accepted.
               if (!r_wr_vld || w_accept) begin
                  r_wr_vld <= w_issue;
                  if (w_issue) begin
                     r_wr_addr <= r_base + AW'(w_wr_ptr_nxt[LW-1:0]);
                     r_wr_data <= w_wr_data;
                     r_wr_mask <= w_mask;
                  end
               end
            end
            default: r_wr_vld <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < LANES; j++)
         if (w_cap[j])
            r_entry[r_lane_row[j][LW-1:0]][j*DW +: DW] <= mxu_mm_wb_data[j*DW +: DW];
   end

   assign lsu_mm_wb_busy        = r_busy;
   assign lsu_mm_wb_done        = r_done;
   assign lsu_mm_wb_ram_wr_vld  = r_wr_vld;
   assign lsu_mm_wb_ram_wr_addr = r_wr_addr;
   assign lsu_mm_wb_ram_wr_data = r_wr_data;
   assign lsu_mm_wb_ram_wr_mask = r_wr_mask;

endmodule
`default_nettype wire

// File: tb/tb_mm_wb_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mm_wb_buffer : scoreboard bench for mm_wb_buffer with a row-level model. |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_mm_wb_buffer;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ctrl_vld = 1'b0;
   logic [3:0]    row_len = '0;
   logic [3:0]    col_len = '0;
   logic [11:0]   start_addr = '0;
   logic          busy;
   logic          done;
   logic [15:0]   mvld = '0;
   logic [127:0]  mdata = '0;
   logic          wr_vld;
   logic          wr_rdy = 1'b1;
   logic [7:0]    wr_addr;
   logic [127:0]  wr_data;
   logic [15:0]   wr_mask;

   always #5 clk = ~clk;

   mm_wb_buffer #(.LANES(16), .DW(8), .AW(8)) u_dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .lsu_mm_wb_ctrl_vld        (ctrl_vld),
      .lsu_mm_wb_ctrl_row_len    (row_len),
      .lsu_mm_wb_ctrl_col_len    (col_len),
      .lsu_mm_wb_ctrl_start_addr (start_addr),
      .lsu_mm_wb_busy            (busy),
      .lsu_mm_wb_done            (done),
      .mxu_mm_wb_vld             (mvld),
      .mxu_mm_wb_data            (mdata),
      .lsu_mm_wb_ram_wr_vld      (wr_vld),
      .lsu_mm_wb_ram_wr_rdy      (wr_rdy),
      .lsu_mm_wb_ram_wr_addr     (wr_addr),
      .lsu_mm_wb_ram_wr_data     (wr_data),
      .lsu_mm_wb_ram_wr_mask     (wr_mask)
   );

   typedef struct {
      logic [7:0]   addr;
      logic [127:0] data;
      logic [15:0]  mask;
   } wr_t;

   wr_t exp_q [$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  done_cnt = 0;
   int  done_cyc = 0;
   int  acc_cnt = 0;
   bit  exp_busy = 1'b0;
   int  rdy_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] bytemask(input logic [15:0] m);
      logic [127:0] r;
      r = '0;
      for (int j = 0; j < 16; j++) if (m[j]) r[j*8 +: 8] = 8'hFF;
      return r;
   endfunction

   // RAM ready pattern: 0 always 1, 1 random, 2 held low, 3 toggling
   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       wr_rdy = 1'b1;
            1:       wr_rdy = 1'($urandom);
            2:       wr_rdy = 1'b0;
            default: wr_rdy = ~wr_rdy;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every accepted write
   initial begin
      bit  pstall;
      wr_t pw;
      wr_t e;
      pstall = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pstall = 1'b0;
         end else begin
            chk("busy", 128'(busy), 128'(exp_busy));
            if (pstall) begin
               chk("stall_vld",  128'(wr_vld),  128'(1));
               chk("stall_addr", 128'(wr_addr), 128'(pw.addr));
               chk("stall_data", wr_data, pw.data);
               chk("stall_mask", 128'(wr_mask), 128'(pw.mask));
            end
            if (wr_vld && wr_rdy) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: addr %0h arrived, none expected", wr_addr);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", 128'(wr_addr), 128'(e.addr));
                  chk("wr_mask", 128'(wr_mask), 128'(e.mask));
                  chk("wr_data", wr_data & bytemask(e.mask), e.data);
               end
               acc_cnt++;
            end
            pstall  = wr_vld && !wr_rdy;
            pw.addr = wr_addr;
            pw.data = wr_data;
            pw.mask = wr_mask;
            if (done) begin
               chk("done_after_writes", 128'(exp_q.size()), 128'(0));
               done_cnt++;
               done_cyc = cyc;
               exp_busy = 1'b0;
            end
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 128'(busy),    128'(0));
      chk({tag, "_done"}, 128'(done),    128'(0));
      chk({tag, "_vld"},  128'(wr_vld),  128'(0));
      chk({tag, "_addr"}, 128'(wr_addr), 128'(0));
      chk({tag, "_data"}, wr_data,       128'(0));
      chk({tag, "_mask"}, 128'(wr_mask), 128'(0));
   endtask

   task automatic run_job(input logic [11:0] sa, input int rl, input int cl, input bit patt,
                          input bit spur, input int m_col, input int m_drn, input bit lat,
                          input bit guard, input int rst_after);
      logic [7:0] val [16][16];
      wr_t e;
      int  d0, a0, t_last, n;
      bit  aborted;
      for (int i = 0; i <= rl; i++) begin
         e.addr = 8'(int'(sa[11:4]) + i);
         e.mask = '0;
         e.data = '0;
         for (int j = 0; j <= cl; j++) begin
            val[i][j] = patt ? 8'(i * 16 + j) : 8'($urandom);
            e.mask[j] = 1'b1;
            e.data[j*8 +: 8] = val[i][j];
         end
         exp_q.push_back(e);
      end
      d0 = done_cnt;
      a0 = acc_cnt;
      t_last = 0;
      aborted = 1'b0;
      @(posedge clk); #1;
      ctrl_vld = 1'b1; row_len = 4'(rl); col_len = 4'(cl); start_addr = sa;
      @(posedge clk); #1;
      ctrl_vld = 1'b0; row_len = 4'($urandom); col_len = 4'($urandom); start_addr = 12'($urandom);
      exp_busy = 1'b1;
      rdy_mode = m_col;
      for (int t = 0; t <= rl + cl && !aborted; t++) begin
         mdata = {$urandom, $urandom, $urandom, $urandom};
         mvld  = '0;
         for (int j = 0; j < 16; j++) begin
            if (j <= cl) begin
               if (t - j >= 0 && t - j <= rl) begin
                  mvld[j] = 1'b1;
                  mdata[j*8 +: 8] = val[t-j][j];
               end
            end else if (spur) begin
               mvld[j] = 1'($urandom);
            end
         end
         if (guard && t == 2) begin
            ctrl_vld = 1'b1; start_addr = sa ^ 12'h550; row_len = 4'($urandom); col_len = 4'($urandom);
         end else begin
            ctrl_vld = 1'b0;
         end
         t_last = cyc;
         @(posedge clk); #1;
         if (rst_after >= 0 && acc_cnt - a0 >= rst_after) aborted = 1'b1;
      end
      mvld = '0;
      ctrl_vld = 1'b0;
      rdy_mode = m_drn;
      n = 0;
      while (done_cnt == d0 && n < 3000 && !aborted) begin
         @(posedge clk); #1;
         n++;
         if (rst_after >= 0 && acc_cnt - a0 >= rst_after) aborted = 1'b1;
      end
      if (aborted) begin
         rst_n = 1'b0;
         exp_busy = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b1;
         @(negedge clk);
         chk_zero("abort");
         exp_q.delete();
         rdy_mode = 0;
         repeat (40) @(posedge clk);
         #1;
         chk("no_done_after_reset", 128'(done_cnt), 128'(d0));
      end else if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done after %0d cycles, expected one", n);
         exp_q.delete();
      end else begin
         if (lat) chk("done_latency", 128'(done_cyc - t_last), 128'(2));
         repeat (3) @(posedge clk);
         #1;
         chk("writes_complete", 128'(exp_q.size()), 128'(0));
         chk("done_single", 128'(done_cnt - d0), 128'(1));
      end
      rdy_mode = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      // full 16x16 tile with i*16+j pattern
      run_job(12'h200, 15, 15, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, -1);
      // small tile with spurious lanes
      run_job(12'h340, 2, 3, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, -1);
      // backpressure: stalled during collection, then toggling ready
      run_job(12'h500, 7, 7, 1'b0, 1'b0, 2, 3, 1'b0, 1'b0, -1);
      // line address wrap
      run_job(12'hFE0, 3, 9, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, -1);
      // reset after three rows accepted, then a clean job from row 0
      run_job(12'h100, 7, 7, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 3);
      run_job(12'h100, 7, 7, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, -1);
      // second ctrl_vld while busy must be ignored
      run_job(12'h0A0, 5, 6, 1'b0, 1'b1, 1, 1, 1'b0, 1'b1, -1);
      for (int k = 0; k < 6; k++)
         run_job(12'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, -1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
